// File: rtl/stft_pkg.sv
// Shared STFT datapath constants and the signed round+saturate helper used by the
// complex multiplier and the FFT butterflies.
package stft_pkg;

  localparam int unsigned STFT_DATA_W = 16;
  localparam int unsigned STFT_FRAC_W = 15;

  localparam bit ROUND_TRUNC   = 1'b0;
  localparam bit ROUND_HALF_UP = 1'b1;
  localparam bit SAT_WRAP      = 1'b0;
  localparam bit SAT_CLIP      = 1'b1;

  typedef struct packed {
    logic               clip;
    logic signed [63:0] val;
  } rs_result_t;

  // Works on a 64-bit sign-extended accumulator so any 2*data_w+1 input up to 63 bits fits.
  function automatic rs_result_t round_sat(input logic signed [63:0] x,
                                           input int unsigned data_w,
                                           input int unsigned frac_w,
                                           input bit rnd,
                                           input bit sat);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    rs_result_t         res;
    r = x;
    if (rnd) begin
      r = r + (64'sd1 <<< (frac_w - 1));
    end
    r     = r >>> frac_w;
    max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (data_w - 1));
    res.clip = 1'b0;
    res.val  = r;
    if (sat) begin
      if (r > max_v) begin
        res.val  = max_v;
        res.clip = 1'b1;
      end else if (r < min_v) begin
        res.val  = min_v;
        res.clip = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cplx_round_sat.sv
// Narrows one 2*DATA_W+1 bit product sum to DATA_W bits with optional rounding and
// saturation; clip reports that the value was clamped.
module cplx_round_sat
  import stft_pkg::*;
#(
  parameter int unsigned DATA_W = STFT_DATA_W,
  parameter int unsigned FRAC_W = STFT_FRAC_W,
  parameter bit          ROUND  = ROUND_HALF_UP,
  parameter bit          SAT    = SAT_CLIP
) (
  input  logic signed [2*DATA_W:0]   din,
  output logic        [DATA_W-1:0]   dout,
  output logic                       clip
);

  logic signed [63:0] din_ext;
  rs_result_t         res;
  logic               unused_hi;

  always_comb begin
    din_ext   = 64'(din);
    res       = round_sat(din_ext, DATA_W, FRAC_W, ROUND, SAT);
    dout      = res.val[DATA_W-1:0];
    clip      = res.clip;
    // Upper bits only matter in wrap mode, where they are deliberately discarded.
    unused_hi = ^res.val[63:DATA_W];
  end

endmodule

// File: rtl/complex_mult_pipe.sv
// Three-stage pipelined fixed-point complex multiplier (a+jb)(c+/-jd) with
// valid/ready backpressure, tlast passthrough, rounding and saturation.
module complex_mult_pipe
  import stft_pkg::*;
#(
  parameter int unsigned DATA_W = STFT_DATA_W,
  parameter int unsigned FRAC_W = STFT_FRAC_W,
  parameter bit          ROUND  = ROUND_HALF_UP,
  parameter bit          SAT    = SAT_CLIP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  input  logic                     conj_b,
  input  logic signed [DATA_W-1:0] re_in1,
  input  logic signed [DATA_W-1:0] im_in1,
  input  logic signed [DATA_W-1:0] re_in2,
  input  logic signed [DATA_W-1:0] im_in2,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic        [DATA_W-1:0] re_out,
  output logic        [DATA_W-1:0] im_out,
  output logic                     sat_flag
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned SW = 2 * DATA_W + 1;

  logic ce;

  logic                     s1_valid, s1_last, s1_conj;
  logic signed [DATA_W-1:0] s1_a, s1_b, s1_c, s1_d;
  logic                     s2_valid, s2_last, s2_conj;
  logic signed [PW-1:0]     s2_ac, s2_bd, s2_ad, s2_bc;

  logic signed [SW-1:0]     ac_x, bd_x, ad_x, bc_x;
  logic signed [SW-1:0]     re_sum, im_sum;
  logic        [DATA_W-1:0] re_rs, im_rs;
  logic                     re_clip, im_clip;

  // The whole pipe moves as one; holding every stage keeps bubble spacing intact.
  assign ce       = ~m_tvalid | m_tready;
  assign s_tready = ce & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_conj  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_conj  <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      sat_flag <= 1'b0;
      re_out   <= '0;
      im_out   <= '0;
    end else if (ce) begin
      s1_valid <= s_tvalid & s_tready;
      s1_last  <= s_tlast;
      s1_conj  <= conj_b;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s2_conj  <= s1_conj;
      m_tvalid <= s2_valid;
      m_tlast  <= s2_last;
      sat_flag <= s2_valid & (re_clip | im_clip);
      re_out   <= re_rs;
      im_out   <= im_rs;
    end
  end

  // Datapath registers carry no reset so the multiplies map cleanly onto DSP blocks.
  always_ff @(posedge clk) begin
    if (ce) begin
      s1_a  <= re_in1;
      s1_b  <= im_in1;
      s1_c  <= re_in2;
      s1_d  <= im_in2;
      s2_ac <= s1_a * s1_c;
      s2_bd <= s1_b * s1_d;
      s2_ad <= s1_a * s1_d;
      s2_bc <= s1_b * s1_c;
    end
  end

  always_comb begin
    ac_x = SW'(s2_ac);
    bd_x = SW'(s2_bd);
    ad_x = SW'(s2_ad);
    bc_x = SW'(s2_bc);
    if (s2_conj) begin
      re_sum = ac_x + bd_x;
      im_sum = bc_x - ad_x;
    end else begin
      re_sum = ac_x - bd_x;
      im_sum = ad_x + bc_x;
    end
  end

  cplx_round_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ROUND  (ROUND),
    .SAT    (SAT)
  ) u_re_rs (
    .din  (re_sum),
    .dout (re_rs),
    .clip (re_clip)
  );

  cplx_round_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ROUND  (ROUND),
    .SAT    (SAT)
  ) u_im_rs (
    .din  (im_sum),
    .dout (im_rs),
    .clip (im_clip)
  );

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Scoreboard bench for complex_mult_pipe: a saturating and a wrapping instance share
// stimulus; the driver pushes expectations, the monitor pops and compares.
module tb_complex_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tlast, conj_b, m_tready;
  logic [15:0] re_in1, im_in1, re_in2, im_in2;
  logic        s_tready, m_tvalid, m_tlast, sat_flag;
  logic [15:0] re_out, im_out;
  logic        w_s_tready, w_m_tvalid, w_m_tlast, w_sat_flag;
  logic [15:0] w_re_out, w_im_out;

  always #5 clk = ~clk;

  complex_mult_pipe #(
    .DATA_W (16),
    .FRAC_W (15),
    .ROUND  (1'b1),
    .SAT    (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .conj_b   (conj_b),
    .re_in1   (re_in1),
    .im_in1   (im_in1),
    .re_in2   (re_in2),
    .im_in2   (im_in2),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .re_out   (re_out),
    .im_out   (im_out),
    .sat_flag (sat_flag)
  );

  complex_mult_pipe #(
    .DATA_W (16),
    .FRAC_W (15),
    .ROUND  (1'b1),
    .SAT    (1'b0)
  ) dut_wrap (
    .clk      (clk),
    .rst      (rst),
    .s_tvalid (s_tvalid),
    .s_tready (w_s_tready),
    .s_tlast  (s_tlast),
    .conj_b   (conj_b),
    .re_in1   (re_in1),
    .im_in1   (im_in1),
    .re_in2   (re_in2),
    .im_in2   (im_in2),
    .m_tvalid (w_m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (w_m_tlast),
    .re_out   (w_re_out),
    .im_out   (w_im_out),
    .sat_flag (w_sat_flag)
  );

  typedef struct {
    logic [15:0] re;
    logic [15:0] im;
    logic [15:0] re_w;
    logic [15:0] im_w;
    bit          sat;
    bit          last;
    bit          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;

  logic [15:0] mix_tab [6][4] = '{
    '{16'h2000, 16'h6000, 16'h4000, 16'h2000},
    '{16'h8000, 16'h8000, 16'h8000, 16'h8000},
    '{16'hE000, 16'h1000, 16'h7FFF, 16'hC000},
    '{16'h1234, 16'hF00D, 16'h0800, 16'h3000},
    '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000},
    '{16'h0001, 16'hFFFF, 16'h4000, 16'h4000}
  };

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Independent reference: wide integer arithmetic, round half-up, then clamp or wrap.
  function automatic logic [16:0] ref_rs(input longint x, input bit sat);
    longint r;
    r = (x + 16384) >>> 15;
    if (sat && r > 32767) return {1'b1, 16'h7FFF};
    if (sat && r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                                 input logic [15:0] d, input bit conj, input bit last);
    longint ai, bi, ci, di, re_x, im_x;
    logic [16:0] rr, ri, wr, wi;
    exp_t e;
    ai = longint'($signed(a));
    bi = longint'($signed(b));
    ci = longint'($signed(c));
    di = longint'($signed(d));
    re_x = conj ? (ai * ci + bi * di) : (ai * ci - bi * di);
    im_x = conj ? (bi * ci - ai * di) : (ai * di + bi * ci);
    rr = ref_rs(re_x, 1'b1);
    ri = ref_rs(im_x, 1'b1);
    wr = ref_rs(re_x, 1'b0);
    wi = ref_rs(im_x, 1'b0);
    e.re = rr[15:0];
    e.im = ri[15:0];
    e.re_w = wr[15:0];
    e.im_w = wi[15:0];
    e.sat = rr[16] | ri[16];
    e.last = last;
    e.lat = 1'b0;
    e.acc = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] re, input logic [15:0] im, input logic [15:0] re_w,
                              input logic [15:0] im_w, input bit sat, input bit last);
    exp_t e;
    e.re = re;
    e.im = im;
    e.re_w = re_w;
    e.im_w = im_w;
    e.sat = sat;
    e.last = last;
    e.lat = 1'b0;
    e.acc = 0;
    return e;
  endfunction

  // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                      input logic [15:0] d, input bit conj, input bit last, input exp_t e,
                      input bit lat);
    int n = 0;
    s_tvalid = 1'b1;
    re_in1 = a;
    im_in1 = b;
    re_in2 = c;
    im_in2 = d;
    conj_b = conj;
    s_tlast = last;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tready && n < 50);
    if (s_tready) begin
      e.lat = lat;
      e.acc = cyc;
      q.push_back(e);
    end else begin
      total++;
      $display("FAIL send_timeout: actual s_tready=0 required 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    #1;
  endtask

  // Monitor: compares at every emitted beat and checks hold behaviour while stalled.
  logic [15:0] h_re, h_im;
  logic        h_last, h_sat;
  bit          h_stall = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst || !m_tvalid) begin
      h_stall = 1'b0;
    end else begin
      if (h_stall) begin
        check("hold_re", re_out, h_re);
        check("hold_im", im_out, h_im);
        check("hold_last", m_tlast, h_last);
        check("hold_sat", sat_flag, h_sat);
      end
      if (!m_tready) begin
        check("stall_s_tready", s_tready, 0);
        h_re = re_out;
        h_im = im_out;
        h_last = m_tlast;
        h_sat = sat_flag;
        h_stall = 1'b1;
      end else begin
        h_stall = 1'b0;
        if (q.size() == 0) begin
          check("unexpected_beat", m_tvalid, 0);
        end else begin
          e = q.pop_front();
          check("re_out", re_out, e.re);
          check("im_out", im_out, e.im);
          check("sat_flag", sat_flag, e.sat);
          check("m_tlast", m_tlast, e.last);
          check("wrap_valid", w_m_tvalid, 1);
          check("wrap_re_out", w_re_out, e.re_w);
          check("wrap_im_out", w_im_out, e.im_w);
          check("wrap_sat_flag", w_sat_flag, 0);
          if (e.lat) check("latency", cyc - e.acc, 3);
        end
      end
    end
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    conj_b = 1'b0;
    m_tready = 1'b1;
    re_in1 = '0;
    im_in1 = '0;
    re_in2 = '0;
    im_in2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_re_out", re_out, 0);
    check("rst_im_out", im_out, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_wrap_s_tready", w_s_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Hand-computed directed vectors, isolated so latency is exact.
    send(16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0, 1'b0,
         mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    send(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b0,
         mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    send(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0,
         mk(16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b0), 1'b1);
    send(16'h2000, 16'h6000, 16'h4000, 16'h2000, 1'b0, 1'b1,
         mk(16'hF800, 16'h3800, 16'hF800, 16'h3800, 1'b0, 1'b1), 1'b0);
    drain();

    // tlast on beat 3 only, mode alternating, back to back.
    for (int i = 0; i < 6; i++) begin
      e = model(mix_tab[i][0], mix_tab[i][1], mix_tab[i][2], mix_tab[i][3], i[0], i == 2);
      send(mix_tab[i][0], mix_tab[i][1], mix_tab[i][2], mix_tab[i][3], i[0], i == 2, e, 1'b0);
    end
    drain();

    // Random stream with downstream stalled for five cycles mid-flight.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [15:0] a, b, c, d;
          bit cj;
          a = 16'($urandom);
          b = 16'($urandom);
          c = 16'($urandom);
          d = 16'($urandom);
          cj = 1'($urandom_range(1, 0));
          e = model(a, b, c, d, cj, i == 7);
          send(a, b, c, d, cj, i == 7, e, 1'b0);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        m_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight: both must vanish.
    send(16'h4000, 16'h4000, 16'h4000, 16'hC000, 1'b0, 1'b0,
         mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0), 1'b0);
    send(16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1,
         mk(16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 1'b1, 1'b1), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_wrap_m_tvalid", w_m_tvalid, 0);
    check("midrst_s_tready", s_tready, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    send(16'h4000, 16'h4000, 16'h4000, 16'h4000, 1'b1, 1'b1,
         mk(16'h4000, 16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b1), 1'b1);
    drain();
    repeat (4) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
